// File: rtl/clk_net_pkg.sv
// clk_net_pkg: shared FSM state encoding and default timing constants for clock selection
package clk_net_pkg;
    typedef enum logic [1:0] {IDLE, SWITCH, SETTLE} state_t;
    localparam int DEF_TIMEOUT    = 16;
    localparam int DEF_OK_EDGES   = 4;
    localparam int DEF_SETTLE_CYC = 8;
endpackage

// File: rtl/clk_activity_mon.sv
// clk_activity_mon: judges whether a raw clock sampled by the reference clock is alive
module clk_activity_mon
    import clk_net_pkg::*;
#(
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int OK_EDGES = DEF_OK_EDGES
) (
    input  logic clk,
    input  logic rst,
    input  logic mon,
    output logic ok
);
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(OK_EDGES + 1);
    logic [2:0]    r_sync;
    logic [IW-1:0] r_idle;
    logic [GW-1:0] r_good;
    logic          r_ok;
    logic          w_edge;
    logic          w_timeout;
    assign w_edge    = r_sync[1] & ~r_sync[2];
    assign w_timeout = r_idle == IW'(TIMEOUT);
    assign ok        = r_ok;
    // two synchronizer flops plus a history flop, idle/good-edge counters and the registered verdict
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_idle <= '0;
            r_good <= '0;
            r_ok   <= 1'b0;
        end else begin
            r_sync <= {r_sync[1:0], mon};
            r_idle <= w_edge ? '0 : w_timeout ? r_idle : r_idle + IW'(1);
            r_good <= w_timeout ? '0 : (w_edge && r_good != GW'(OK_EDGES)) ? r_good + GW'(1) : r_good;
            r_ok   <= !w_timeout && r_good == GW'(OK_EDGES);
        end
    end
endmodule

// File: rtl/clk_sel_ctrl.sv
// clk_sel_ctrl: request/failover controller for a glitch-free two-clock mux (automatic failover under CLK_SEL_AUTO_FAILOVER_EN)
module clk_sel_ctrl
    import clk_net_pkg::*;
#(
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int OK_EDGES   = DEF_OK_EDGES,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic clk0_mon,
    input  logic clk1_mon,
    input  logic sw_req,
    input  logic sw_sel,
    output logic sel,
    output logic busy,
    output logic done,
    output logic reject,
    output logic clk0_ok,
    output logic clk1_ok,
    output logic fail_evt
);
    localparam int CW = $clog2(SETTLE_CYC + 1);
    state_t        r_state;
    logic          r_sel;
    logic          r_busy;
    logic          r_done;
    logic          r_reject;
    logic          r_fail;
    logic [CW-1:0] r_cnt;
    logic [1:0]    w_ok;
    logic          w_fo;
    clk_activity_mon #(.TIMEOUT(TIMEOUT), .OK_EDGES(OK_EDGES)) u_mon0 (
        .clk(clk), .rst(rst), .mon(clk0_mon), .ok(clk0_ok)
    );
    clk_activity_mon #(.TIMEOUT(TIMEOUT), .OK_EDGES(OK_EDGES)) u_mon1 (
        .clk(clk), .rst(rst), .mon(clk1_mon), .ok(clk1_ok)
    );
    assign w_ok = {clk1_ok, clk0_ok};
`ifdef CLK_SEL_AUTO_FAILOVER_EN
    assign w_fo = !w_ok[r_sel] && w_ok[~r_sel];
`else
    assign w_fo = 1'b0;
`endif
    assign sel      = r_sel;
    assign busy     = r_busy;
    assign done     = r_done;
    assign reject   = r_reject;
    assign fail_evt = r_fail;
    // request arbitration, one-cycle select toggle, then a fixed settle window before done
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_sel    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_reject <= 1'b0;
            r_fail   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_done   <= 1'b0;
            r_reject <= 1'b0;
            r_fail   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (sw_req) begin
                        if (sw_sel == r_sel) r_done <= 1'b1;
                        else if (!w_ok[sw_sel]) r_reject <= 1'b1;
                        else begin
                            r_state <= SWITCH;
                            r_busy  <= 1'b1;
                        end
                    end else if (w_fo) begin
                        r_state <= SWITCH;
                        r_busy  <= 1'b1;
                        r_fail  <= 1'b1;
                    end
                end
                SWITCH: begin
                    r_sel   <= ~r_sel;
                    r_cnt   <= '0;
                    r_state <= SETTLE;
                end
                SETTLE: begin
                    if (r_cnt == CW'(SETTLE_CYC - 1)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else r_cnt <= r_cnt + CW'(1);
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_clk_sel_ctrl.sv
// tb_clk_sel_ctrl: directed plus randomized checks of clk_sel_ctrl against a request-level model
module tb_clk_sel_ctrl;
    localparam int SETTLE = 8;
    logic clk = 1'b0;
    logic rst, clk0_mon, clk1_mon, sw_req, sw_sel;
    logic sel, busy, done, reject, clk0_ok, clk1_ok, fail_evt;
    int errors = 0;
    int checks = 0;
    int half0, half1, ph0, ph1;
    logic [1:0] exp_ok;
    logic exp_sel;

    clk_sel_ctrl dut (
        .clk(clk), .rst(rst), .clk0_mon(clk0_mon), .clk1_mon(clk1_mon),
        .sw_req(sw_req), .sw_sel(sw_sel), .sel(sel), .busy(busy), .done(done),
        .reject(reject), .clk0_ok(clk0_ok), .clk1_ok(clk1_ok), .fail_evt(fail_evt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one reference cycle and drive the monitored clocks (half-period in ref cycles, 0 = stopped)
    task automatic tick();
        @(posedge clk);
        #1;
        if (half0 == 0) clk0_mon = 1'b0;
        else begin
            ph0 = ph0 + 1;
            if (ph0 >= half0) begin ph0 = 0; clk0_mon = ~clk0_mon; end
        end
        if (half1 == 0) clk1_mon = 1'b0;
        else begin
            ph1 = ph1 + 1;
            if (ph1 >= half1) begin ph1 = 0; clk1_mon = ~clk1_mon; end
        end
    endtask

    // let the monitors reach a steady verdict: running clocks are good, stopped ones dead
    task automatic stabilize();
        repeat (80) tick();
        exp_ok = {half1 != 0, half0 != 0};
`ifdef CLK_SEL_AUTO_FAILOVER_EN
        if (!exp_ok[exp_sel] && exp_ok[~exp_sel]) exp_sel = ~exp_sel;
`endif
        chk("clk0_ok_steady", clk0_ok, exp_ok[0]);
        chk("clk1_ok_steady", clk1_ok, exp_ok[1]);
        chk("sel_steady", sel, exp_sel);
        chk("busy_steady", busy, 0);
    endtask

    // issue one request and check the outcome the rules predict
    task automatic request(input logic tgt, input logic noise);
        sw_req = 1'b1;
        sw_sel = tgt;
        tick();
        sw_req = 1'b0;
        if (tgt == exp_sel) begin
            chk("same_done", done, 1);
            chk("same_busy", busy, 0);
            chk("same_reject", reject, 0);
        end else if (!exp_ok[tgt]) begin
            chk("rej_reject", reject, 1);
            chk("rej_done", done, 0);
            chk("rej_sel", sel, exp_sel);
        end else begin
            chk("sw_busy", busy, 1);
            chk("sw_sel_old", sel, exp_sel);
            chk("sw_done0", done, 0);
            tick();
            chk("sw_sel_new", sel, tgt);
            for (int c = 3; c <= SETTLE + 2; c++) begin
                sw_req = (c == 5) ? noise : 1'b0;
                sw_sel = 1'($urandom);
                tick();
                chk("sw_done", done, c == SETTLE + 2);
                chk("sw_busy_t", busy, c < SETTLE + 2);
                chk("sw_reject", reject, 0);
                chk("sw_fail", fail_evt, 0);
            end
            sw_req = 1'b0;
            exp_sel = tgt;
            chk("sw_sel_final", sel, tgt);
        end
        tick();
        chk("pulse_clear", done | reject, 0);
    endtask

    initial begin
        logic seen;
        int i;
        rst = 1'b1; clk0_mon = 1'b0; clk1_mon = 1'b0; sw_req = 1'b0; sw_sel = 1'b0;
        half0 = 2; half1 = 3; ph0 = 0; ph1 = 0; exp_sel = 1'b0; exp_ok = 2'b00;
        repeat (3) tick();
        chk("rst_sel", sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_reject", reject, 0);
        chk("rst_ok0", clk0_ok, 0);
        chk("rst_ok1", clk1_ok, 0);
        chk("rst_fail", fail_evt, 0);
        rst = 1'b0;
        repeat (5) tick();
        chk("early_ok0", clk0_ok, 0);
        chk("early_ok1", clk1_ok, 0);
        stabilize();
        request(1'b0, 1'b0);
        request(1'b1, 1'b1);
        request(1'b0, 1'b0);
        half1 = 0;
        stabilize();
        request(1'b1, 1'b0);
        half1 = 3;
        stabilize();
        sw_req = 1'b1; sw_sel = ~exp_sel;
        tick();
        sw_req = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_sel", sel, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_ok0", clk0_ok, 0);
        chk("mid_rst_ok1", clk1_ok, 0);
        exp_sel = 1'b0;
        seen = 1'b0;
        repeat (12) begin tick(); seen = seen | done; end
        chk("mid_rst_no_done", seen, 0);
        stabilize();
`ifdef CLK_SEL_AUTO_FAILOVER_EN
        half0 = 0;
        seen = 1'b0;
        for (i = 0; i < 60 && !seen; i++) begin tick(); seen = fail_evt; end
        chk("fo_seen", seen, 1);
        chk("fo_latency", i >= 14 && i <= 26, 1);
        chk("fo_ok0", clk0_ok, 0);
        tick();
        chk("fo_sel", sel, 1);
        for (int c = 2; c <= SETTLE + 1; c++) begin
            tick();
            chk("fo_done", done, c == SETTLE + 1);
        end
        exp_sel = 1'b1;
`else
        half0 = 0;
        seen = 1'b0;
        repeat (40) begin tick(); seen = seen | fail_evt; end
        chk("nofo_fail", seen, 0);
        chk("nofo_ok0", clk0_ok, 0);
        chk("nofo_sel", sel, 0);
`endif
        half0 = 2;
        stabilize();
        for (int k = 0; k < 8; k++) begin
            half0 = $urandom_range(0, 6);
            half1 = $urandom_range(0, 6);
            stabilize();
            for (int r = 0; r < 3; r++) request(1'($urandom), 1'($urandom));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/clk_sel_ctrl.md
CLK_SEL_CTRL -- requirements
Module: clk_sel_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: reference cycles without a monitored-clock edge before that clock is declared dead.
REQ-002 Parameter OK_EDGES, default 4: consecutive timely edges required before a clock is declared good.
REQ-003 Parameter SETTLE_CYC, default 8: reference cycles held in SETTLE after `sel` changes.
REQ-004 Port `clk`, input, 1: reference clock; the only clock of the block.
REQ-005 Port `rst`, input, 1: reset; synchronous, active-high.
REQ-006 Port `clk0_mon`, input, 1: raw clk0, sampled as asynchronous data.
REQ-007 Port `clk1_mon`, input, 1: raw clk1, sampled as asynchronous data.
REQ-008 Port `sw_req`, input, 1: single-cycle switch request.
REQ-009 Port `sw_sel`, input, 1: target select, valid with `sw_req`.
REQ-010 Port `sel`, output, 1: registered select that drives the downstream glitch-free mux.
REQ-011 Port `busy`, output, 1: high while the state is SWITCH or SETTLE.
REQ-012 Port `done`, output, 1: one-cycle pulse when a request completes.
REQ-013 Port `reject`, output, 1: one-cycle pulse when a request is refused.
REQ-014 Port `clk0_ok`, output, 1: clk0 is good; `clk1_ok`, output, 1: clk1 is good.
REQ-015 Port `fail_evt`, output, 1: one-cycle pulse on an automatic failover.

Function
REQ-016 Each monitored input SHALL pass through a 2-flop synchronizer, then a rising-edge detector (third flop).
REQ-017 Per monitor, an idle counter SHALL clear on each detected edge, otherwise increment and saturate at TIMEOUT.
REQ-018 When the idle counter reaches TIMEOUT, `clkN_ok` SHALL deassert on the next cycle and the good-edge counter SHALL clear.
REQ-019 The good-edge counter SHALL increment on each edge while idle < TIMEOUT; `clkN_ok` SHALL assert on the cycle after it reaches OK_EDGES, then saturate.
REQ-020 The FSM SHALL have states IDLE, SWITCH and SETTLE; `sw_req` SHALL be sampled only in IDLE and ignored otherwise (no queueing).
REQ-021 IDLE, `sw_req` with `sw_sel` == `sel`: `done` SHALL pulse next cycle and the FSM SHALL stay in IDLE.
REQ-022 IDLE, `sw_req` with `sw_sel` != `sel` and target clock not ok: `reject` SHALL pulse next cycle and `sel` SHALL be unchanged.
REQ-023 IDLE, `sw_req` with `sw_sel` != `sel` and target ok: the FSM SHALL go to SWITCH.
REQ-024 SWITCH (1 cycle): `sel` SHALL toggle, then the FSM SHALL go to SETTLE.
REQ-025 SETTLE: the block SHALL wait SETTLE_CYC cycles, then pulse `done` and return to IDLE.
REQ-026 Request-to-`done` latency for a real switch SHALL be SETTLE_CYC+2 cycles.
REQ-027 The target clock dying during SETTLE SHALL NOT abort the sequence; failover re-evaluates in IDLE.
REQ-028 `done`, `reject` and `fail_evt` SHALL be mutually exclusive in any cycle.

Reset
REQ-029 While `rst`=1 on a `clk` edge: `sel`=0, all outputs=0, counters=0, synchronizer flops=0, state=IDLE.
REQ-030 `rst` asserted mid-SETTLE SHALL abort with no `done` pulse and force `sel`=0.
REQ-031 Both clocks SHALL read not-ok after reset until OK_EDGES edges have been seen on each.

Configuration
REQ-032 Macro CLK_SEL_AUTO_FAILOVER_EN, when defined: in IDLE with no `sw_req`, if the current clock is not ok and the other is ok, the FSM SHALL enter SWITCH, pulse `fail_evt` on entry, and end with the normal SETTLE and `done`.
REQ-033 `sw_req` and failover eligible in the same IDLE cycle: `sw_req` SHALL win.
REQ-034 Macro CLK_SEL_AUTO_FAILOVER_EN undefined: no automatic switching; `fail_evt` SHALL be tied to 0.

Structure
REQ-035 Shared package clk_net_pkg SHALL hold the FSM state enum (IDLE/SWITCH/SETTLE) and the default TIMEOUT, OK_EDGES and SETTLE_CYC constants.
REQ-036 Sub-module clk_activity_mon SHALL contain the synchronizer, edge detector, idle counter and good-edge counter, and be instantiated twice.

Verification
REQ-037 clk0_mon period 4, clk1_mon period 6, then `sw_req` with `sw_sel`=1 -> `busy`=1 next cycle, `sel`=1 one cycle later, `done` exactly 10 cycles after `sw_req`.
REQ-038 clk1_mon held at 0, `sw_req` with `sw_sel`=1 -> `reject` pulse next cycle, `sel` stays 0, `done`=0.
REQ-039 `sel`=0, `sw_req` with `sw_sel`=0 -> `done` pulse next cycle, `busy` never asserts.
REQ-040 Failover enabled, both clocks good, then clk0_mon stopped -> `clk0_ok` falls about 17 cycles later, `fail_evt` pulses, `sel`=1, `done` SETTLE_CYC+1 cycles after `fail_evt`.
REQ-041 `rst` pulsed during SETTLE -> `sel`=0 and `busy`=0 the next cycle, no `done` pulse, both ok flags 0.
REQ-042 Failover disabled, clk0_mon stopped -> `clk0_ok`=0, `sel` stays 0, `fail_evt` never asserts.
